// File: rtl/flappy_game_ctrl.sv
// Frame-rate game sequencer: one PHYS/PIPE/COLL/PUBLISH pass per VS falling edge,
// publishing frame-stable bird/pipe coordinates, score and game state.
module flappy_game_ctrl #(
  parameter int          SCREEN_W = 640,
  parameter int          SCREEN_H = 480,
  parameter int          BIRD_X   = 100,
  parameter int          BIRD_W   = 45,
  parameter int          BIRD_H   = 35,
  parameter int          PIPE_W   = 54,
  parameter int          GAP      = 120,
  parameter int          GAP_MIN  = 100,
  parameter int          SCROLL   = 2,
  parameter int          GRAVITY  = 1,
  parameter int          FLAP_V   = 8,
  parameter int          VMAX     = 10,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic        vs,
  input  logic        flap,
  output logic [18:0] bird_y,
  output logic [18:0] pipe_x,
  output logic [18:0] pipe_y,
  output logic [9:0]  score,
  output logic [1:0]  state,
  output logic        frame_upd
);
  localparam logic [18:0] FLOOR  = 19'(SCREEN_H - BIRD_H);
  localparam logic [18:0] HALF_W = 19'(PIPE_W / 2);
  localparam logic [18:0] HALF_G = 19'(GAP / 2);
  localparam logic [18:0] X_HOME = 19'(SCREEN_W + PIPE_W / 2);
  localparam logic [18:0] Y_HOME = 19'(SCREEN_H / 2);
  localparam logic signed [10:0] FLAP_S = 11'(-FLAP_V);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);
  localparam logic signed [10:0] VMAX_S = 11'(VMAX);

  typedef enum logic [1:0] {IDLE, PLAY, DYING, OVER} game_t;
  typedef enum logic [2:0] {SEQ_IDLE, PHYS, PIPE, COLL, PUBLISH} seq_t;

  game_t gst, gst_nxt;
  seq_t  seq, seq_nxt;

  logic vs_d1, vs_d2, tick;
  logic flap_s1, flap_s2, flap_s3, flap_rise, flap_pend;

  logic [18:0] wy, wpx, wpy;
  logic signed [10:0] vel;
  logic [9:0]  wscore;
  logic [15:0] lfsr;
  logic        hit, go;

  assign tick      = vs_d2 & ~vs_d1;
  assign flap_rise = flap_s2 & ~flap_s3;
  assign state     = gst;

  // PHYS datapath
  logic use_flap, moving;
  logic signed [10:0] vel_g, v_new;
  logic [19:0] ny;
  // PIPE / COLL datapath
  logic [18:0] nx, px_new;
  logic        wrap, pass, overlap_x, out_gap;
  logic [15:0] lfsr_nx;

  always_comb begin
    use_flap  = flap_pend && (gst == PLAY || gst == IDLE);
    moving    = use_flap || gst == PLAY || gst == DYING;
    vel_g     = vel + GRAV_S;
    v_new     = use_flap ? FLAP_S : ((vel_g > VMAX_S) ? VMAX_S : vel_g);
    ny        = {1'b0, wy} + {{9{v_new[10]}}, v_new};
    nx        = wpx - 19'(SCROLL);
    wrap      = nx <= HALF_W;
    px_new    = wrap ? X_HOME : nx;
    pass      = (wpx > 19'(BIRD_X)) && (px_new <= 19'(BIRD_X));
    lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    overlap_x = (19'(BIRD_X + BIRD_W) > wpx - HALF_W) && (19'(BIRD_X) < wpx + HALF_W);
    out_gap   = (wy < wpy - HALF_G) || (wy + 19'(BIRD_H) > wpy + HALF_G);
  end

  always_comb begin
    seq_nxt = seq;
    gst_nxt = gst;
    case (seq)
      SEQ_IDLE: if (tick) seq_nxt = PHYS;
      PHYS:     seq_nxt = PIPE;
      PIPE:     seq_nxt = COLL;
      COLL:     seq_nxt = PUBLISH;
      PUBLISH: begin
        seq_nxt = SEQ_IDLE;
        case (gst)
          IDLE:  if (go) gst_nxt = PLAY;
          PLAY:  if (hit) gst_nxt = DYING;
          DYING: if (wy == FLOOR) gst_nxt = OVER;
          OVER:  if (go) gst_nxt = IDLE;
          default: gst_nxt = IDLE;
        endcase
      end
      default: seq_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      vs_d1     <= 1'b1;
      vs_d2     <= 1'b1;
      flap_s1   <= 1'b0;
      flap_s2   <= 1'b0;
      flap_s3   <= 1'b0;
      flap_pend <= 1'b0;
      seq       <= SEQ_IDLE;
      gst       <= IDLE;
    end else begin
      vs_d1     <= vs;
      vs_d2     <= vs_d1;
      flap_s1   <= flap;
      flap_s2   <= flap_s1;
      flap_s3   <= flap_s2;
      // An edge landing in the PHYS cycle itself carries over to the next frame
      flap_pend <= (seq == PHYS) ? flap_rise : (flap_pend | flap_rise);
      seq       <= seq_nxt;
      gst       <= gst_nxt;
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wy        <= Y_HOME;
      vel       <= '0;
      wpx       <= X_HOME;
      wpy       <= Y_HOME;
      wscore    <= '0;
      lfsr      <= SEED;
      hit       <= 1'b0;
      go        <= 1'b0;
      bird_y    <= Y_HOME;
      pipe_x    <= X_HOME;
      pipe_y    <= Y_HOME;
      score     <= '0;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= 1'b0;
      case (seq)
        SEQ_IDLE: begin
          hit <= 1'b0;
          go  <= 1'b0;
        end
        PHYS: begin
          go <= flap_pend && (gst == IDLE || gst == OVER);
          if (moving) begin
            if (ny[19]) begin
              wy  <= '0;
              vel <= '0;
            end else if (ny[18:0] >= FLOOR) begin
              wy  <= FLOOR;
              vel <= '0;
              hit <= 1'b1;
            end else begin
              wy  <= ny[18:0];
              vel <= v_new;
            end
          end
        end
        PIPE: if (gst == PLAY) begin
          wpx <= px_new;
          if (wrap) begin
            lfsr <= lfsr_nx;
            wpy  <= 19'(GAP_MIN) + {11'd0, lfsr_nx[7:0]};
          end
          if (pass && wscore != 10'd999) wscore <= wscore + 10'd1;
        end
        COLL: if (gst == PLAY && overlap_x && out_gap) hit <= 1'b1;
        PUBLISH: begin
          frame_upd <= 1'b1;
          if (gst == OVER && go) begin
            // Restart keeps the LFSR so successive games see new gaps
            wy     <= Y_HOME;
            vel    <= '0;
            wpx    <= X_HOME;
            wpy    <= Y_HOME;
            wscore <= '0;
            bird_y <= Y_HOME;
            pipe_x <= X_HOME;
            pipe_y <= Y_HOME;
            score  <= '0;
          end else begin
            bird_y <= wy;
            pipe_x <= wpx;
            pipe_y <= wpy;
            score  <= wscore;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed bench for flappy_game_ctrl: idle frames, start, fall-to-death, restart,
// scoring/wrap with a flap controller, pipe collision, mid-sequence reset, double flap.
module tb_flappy_game_ctrl;
  logic        vga_clk = 1'b0;
  logic        reset, vs, flap;
  logic [18:0] bird_y, pipe_x, pipe_y;
  logic [9:0]  score;
  logic [1:0]  state;
  logic        frame_upd;

  int tests = 0;
  int fails = 0;
  int lat;
  bit upd_one;

  flappy_game_ctrl dut (
    .vga_clk(vga_clk), .reset(reset), .vs(vs), .flap(flap),
    .bird_y(bird_y), .pipe_x(pipe_x), .pipe_y(pipe_y),
    .score(score), .state(state), .frame_upd(frame_upd)
  );

  always #5 vga_clk = ~vga_clk;

  // One vs frame; lat = negedges from vs low to frame_upd seen (0 on timeout)
  task automatic frame();
    int n;
    n = 0;
    @(negedge vga_clk);
    vs = 1'b0;
    do begin
      @(negedge vga_clk);
      n++;
    end while (!frame_upd && n < 20);
    lat = frame_upd ? n : 0;
    @(negedge vga_clk);
    upd_one = !frame_upd;
    vs = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic flap_pulse();
    @(negedge vga_clk);
    flap = 1'b1;
    repeat (3) @(negedge vga_clk);
    flap = 1'b0;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; vs = 1'b1; flap = 1'b0;
    repeat (3) @(negedge vga_clk);
    tests++; if (bird_y !== 19'd240) begin fails++; $display("FAIL reset_bird_y got %0d exp 240", bird_y); end
    tests++; if (pipe_x !== 19'd667) begin fails++; $display("FAIL reset_pipe_x got %0d exp 667", pipe_x); end
    tests++; if (pipe_y !== 19'd240) begin fails++; $display("FAIL reset_pipe_y got %0d exp 240", pipe_y); end
    tests++; if (score !== 10'd0 || state !== 2'd0 || frame_upd !== 1'b0) begin
      fails++; $display("FAIL reset_misc score %0d state %0d upd %0b exp 0 0 0", score, state, frame_upd);
    end
    reset = 1'b0;
    repeat (2) @(negedge vga_clk);
  endtask

  task automatic test_idle_frames();
    for (int f = 0; f < 3; f++) begin
      frame();
      tests++; if (lat != 6) begin fails++; $display("FAIL idle_latency frame %0d got %0d exp 6", f, lat); end
      tests++; if (!upd_one) begin fails++; $display("FAIL idle_upd_width frame %0d got >1 cycle exp 1", f); end
      tests++; if (bird_y !== 19'd240 || pipe_x !== 19'd667 || state !== 2'd0 || score !== 10'd0) begin
        fails++; $display("FAIL idle_hold y %0d x %0d st %0d sc %0d exp 240 667 0 0", bird_y, pipe_x, state, score);
      end
    end
  endtask

  task automatic test_flap_start();
    flap_pulse();
    frame();
    tests++; if (state !== 2'd1 || bird_y !== 19'd232 || pipe_x !== 19'd667) begin
      fails++; $display("FAIL start_entry st %0d y %0d x %0d exp 1 232 667", state, bird_y, pipe_x);
    end
    frame();
    tests++; if (state !== 2'd1 || bird_y !== 19'd225 || pipe_x !== 19'd665) begin
      fails++; $display("FAIL start_second st %0d y %0d x %0d exp 1 225 665", state, bird_y, pipe_x);
    end
  endtask

  task automatic test_fall();
    int n;
    n = 0;
    do begin frame(); n++; end while (state == 2'd1 && n < 60);
    tests++; if (n != 36 || state !== 2'd2) begin fails++; $display("FAIL fall_frames got %0d st %0d exp 36 2", n, state); end
    tests++; if (bird_y !== 19'd445 || pipe_x !== 19'd593 || score !== 10'd0) begin
      fails++; $display("FAIL fall_dying y %0d x %0d sc %0d exp 445 593 0", bird_y, pipe_x, score);
    end
    frame();
    tests++; if (state !== 2'd3 || bird_y !== 19'd445 || pipe_x !== 19'd593) begin
      fails++; $display("FAIL fall_over st %0d y %0d x %0d exp 3 445 593", state, bird_y, pipe_x);
    end
  endtask

  task automatic test_restart();
    flap_pulse();
    frame();
    tests++; if (state !== 2'd0 || bird_y !== 19'd240 || pipe_x !== 19'd667 || pipe_y !== 19'd240 || score !== 10'd0) begin
      fails++; $display("FAIL restart st %0d y %0d x %0d py %0d sc %0d exp 0 240 667 240 0", state, bird_y, pipe_x, pipe_y, score);
    end
  endtask

  task automatic test_score_wrap();
    logic [18:0] prev_px;
    bit seen_score, seen_wrap;
    seen_score = 0; seen_wrap = 0;
    flap_pulse();
    frame();
    tests++; if (state !== 2'd1 || bird_y !== 19'd232) begin fails++; $display("FAIL score_entry st %0d y %0d exp 1 232", state, bird_y); end
    for (int f = 0; f < 400 && !seen_wrap && state == 2'd1; f++) begin
      prev_px = pipe_x;
      if (bird_y >= 19'd230) flap_pulse();
      frame();
      if (prev_px == 19'd103) begin
        tests++; if (pipe_x !== 19'd101 || score !== 10'd0) begin fails++; $display("FAIL score_before x %0d sc %0d exp 101 0", pipe_x, score); end
      end
      if (prev_px == 19'd101) begin
        seen_score = 1;
        tests++; if (pipe_x !== 19'd99 || score !== 10'd1) begin fails++; $display("FAIL score_pass x %0d sc %0d exp 99 1", pipe_x, score); end
      end
      if (prev_px == 19'd29) begin
        seen_wrap = 1;
        tests++; if (pipe_x !== 19'd667 || pipe_y !== 19'd295 || score !== 10'd1) begin
          fails++; $display("FAIL wrap x %0d py %0d sc %0d exp 667 295 1", pipe_x, pipe_y, score);
        end
      end
    end
    tests++; if (!seen_score || !seen_wrap || state !== 2'd1) begin
      fails++; $display("FAIL score_run seen_score %0b seen_wrap %0b st %0d exp 1 1 1", seen_score, seen_wrap, state);
    end
  endtask

  task automatic test_hit();
    int bad, n;
    bad = 0; n = 0;
    for (int f = 0; f < 400 && state == 2'd1; f++) begin
      if (bird_y >= 19'd150) flap_pulse();
      frame();
    end
    tests++; if (state !== 2'd2 || pipe_x !== 19'd171 || score !== 10'd1) begin
      fails++; $display("FAIL hit st %0d x %0d sc %0d exp 2 171 1", state, pipe_x, score);
    end
    // flaps keep coming but must be ignored while dying
    while (state == 2'd2 && n < 80) begin
      flap_pulse();
      frame();
      n++;
      if (pipe_x !== 19'd171 || score !== 10'd1) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL dying_freeze got %0d moved frames exp 0", bad); end
    tests++; if (state !== 2'd3 || bird_y !== 19'd445) begin fails++; $display("FAIL dying_over st %0d y %0d exp 3 445", state, bird_y); end
  endtask

  task automatic test_reset_mid();
    int ups;
    ups = 0;
    @(negedge vga_clk);
    vs = 1'b0;
    repeat (3) @(negedge vga_clk);
    reset = 1'b1;
    vs = 1'b1;
    @(negedge vga_clk);
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge vga_clk);
      if (frame_upd) ups++;
    end
    tests++; if (ups != 0) begin fails++; $display("FAIL reset_mid_upd got %0d pulses exp 0", ups); end
    tests++; if (state !== 2'd0 || score !== 10'd0 || bird_y !== 19'd240 || pipe_x !== 19'd667 || pipe_y !== 19'd240) begin
      fails++; $display("FAIL reset_mid_vals st %0d sc %0d y %0d x %0d py %0d exp 0 0 240 667 240", state, score, bird_y, pipe_x, pipe_y);
    end
  endtask

  task automatic test_double_flap();
    flap_pulse();
    flap_pulse();
    frame();
    tests++; if (state !== 2'd1 || bird_y !== 19'd232) begin fails++; $display("FAIL dbl_flap_entry st %0d y %0d exp 1 232", state, bird_y); end
    frame();
    tests++; if (bird_y !== 19'd225 || pipe_x !== 19'd665) begin fails++; $display("FAIL dbl_flap_next y %0d x %0d exp 225 665", bird_y, pipe_x); end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_flap_start();
    test_fall();
    test_restart();
    test_score_wrap();
    test_hit();
    test_reset_mid();
    test_double_flap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
